// File: rtl/cifrador_pkg.sv
// Shared types and helpers for the parameterised rotate/XOR/add block cipher.
// Word widths up to 64 bits are handled by masking to the live width.
package cifrador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;
    localparam int CNT_W = 8;

    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int n, input int w);
        logic [MAX_W-1:0] xm;
        xm = x & width_mask(w);
        if (n == 0) return xm;
        return ((xm << n) | (xm >> (w - n))) & width_mask(w);
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input int n, input int w);
        logic [MAX_W-1:0] xm;
        xm = x & width_mask(w);
        if (n == 0) return xm;
        return ((xm >> n) | (xm << (w - n))) & width_mask(w);
    endfunction

    // k_i = rotl(key, i mod w) ^ i, with i truncated to the word width
    function automatic logic [MAX_W-1:0] round_key(input logic [MAX_W-1:0] key,
                                                   input logic [CNT_W-1:0] i, input int w);
        return rotl(key, int'(i) % w, w) ^ (64'(i) & width_mask(w));
    endfunction

endpackage

// File: rtl/cifrador_round.sv
// One combinational cipher round; decrypt path exists only with CIFRADOR_DECRYPT_EN.
module cifrador_round
    import cifrador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROT   = 3
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] k_i,
    input  logic             mode,
    output logic [WIDTH-1:0] s_next
);

    logic [WIDTH-1:0] enc;
    assign enc = WIDTH'(rotl(64'(s ^ k_i), ROT, WIDTH)) + k_i;

`ifdef CIFRADOR_DECRYPT_EN
    logic [WIDTH-1:0] dec;
    assign dec    = WIDTH'(rotr(64'(s - k_i), ROT, WIDTH)) ^ k_i;
    assign s_next = mode ? dec : enc;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign s_next      = enc;
`endif

endmodule

// File: rtl/cifrador_param_core.sv
// Iterative block cipher core: one round per cycle, IDLE/RUN/DONE handshake.
// Optional decrypt support is enabled by defining CIFRADOR_DECRYPT_EN.
module cifrador_param_core
    import cifrador_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 4,
    parameter int ROT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             key_valid
);

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cifrador_param_core: WIDTH must be in 4..64");
    end
    if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
        $error("cifrador_param_core: ROUNDS must be in 1..255");
    end
    if (ROT < 1 || ROT > WIDTH - 1) begin : g_bad_rot
        $error("cifrador_param_core: ROT must be in 1..WIDTH-1");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   key_q;
    logic [WIDTH-1:0]   run_key_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               key_valid_q;
    logic               mode_q;
    logic               accept;
    logic               last_round;
    logic [CNT_W-1:0]   round_idx;
    logic [WIDTH-1:0]   k_i;
    logic [WIDTH-1:0]   s_next;

    assign in_ready   = (state_q == ST_IDLE) && key_valid_q;
    assign busy       = (state_q == ST_RUN);
    assign out_valid  = (state_q == ST_DONE);
    assign out_data   = out_data_q;
    assign key_valid  = key_valid_q;

    assign accept     = in_valid && in_ready;
    assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));
    // decrypt walks the key schedule backwards
    assign round_idx  = mode_q ? (CNT_W'(ROUNDS - 1) - cnt_q) : cnt_q;
    assign k_i        = WIDTH'(round_key(64'(run_key_q), round_idx, WIDTH));

    cifrador_round #(
        .WIDTH (WIDTH),
        .ROT   (ROT)
    ) u_round (
        .s      (data_q),
        .k_i    (k_i),
        .mode   (mode_q),
        .s_next (s_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)     state_d = ST_RUN;
            ST_RUN:  if (last_round) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            run_key_q   <= '0;
            data_q      <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (key_load && state_q != ST_RUN) begin
                key_q       <= key_in;
                key_valid_q <= 1'b1;
            end
            // the block snapshots the key it was accepted with
            if (state_q == ST_IDLE && accept) begin
                data_q    <= in_data;
                run_key_q <= key_q;
                cnt_q     <= '0;
            end
            if (state_q == ST_RUN) begin
                data_q <= s_next;
                cnt_q  <= cnt_q + 1'b1;
                if (last_round) out_data_q <= s_next;
            end
        end
    end

`ifdef CIFRADOR_DECRYPT_EN
    always_ff @(posedge clk) begin
        if (rst)                               mode_q <= 1'b0;
        else if (state_q == ST_IDLE && accept) mode_q <= in_mode;
    end
`else
    logic unused_in_mode;
    assign unused_in_mode = in_mode;
    assign mode_q         = 1'b0;
`endif

endmodule

// File: tb/tb_cifrador_param_core.sv
// Bench for cifrador_param_core: ROUNDS=1 instance (index 0) and default instance (index 1).
module tb_cifrador_param_core;

`ifdef CIFRADOR_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif
    localparam int ROT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s[2], key_load_s[2], in_valid_s[2], in_ready_s[2], in_mode_s[2];
    logic       out_valid_s[2], out_ready_s[2], busy_s[2], key_valid_s[2];
    logic [7:0] key_in_s[2], in_data_s[2], out_data_s[2];

    int n_cmp = 0;
    int n_bad = 0;

    cifrador_param_core #(.WIDTH(8), .ROUNDS(1), .ROT(3)) u_r1 (
        .clk(clk), .rst(rst_s[0]), .key_load(key_load_s[0]), .key_in(key_in_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .in_mode(in_mode_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_data(out_data_s[0]), .busy(busy_s[0]), .key_valid(key_valid_s[0])
    );

    cifrador_param_core u_r4 (
        .clk(clk), .rst(rst_s[1]), .key_load(key_load_s[1]), .key_in(key_in_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .in_mode(in_mode_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_data(out_data_s[1]), .busy(busy_s[1]), .key_valid(key_valid_s[1])
    );

    function automatic int rounds_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
        logic [15:0] dd;
        int          m;
        dd = {x, x};
        m  = n % 8;
        return dd[15-m -: 8];
    endfunction

    // Reference cipher straight from the round equations
    function automatic logic [7:0] model(input logic [7:0] key, input logic [7:0] data,
                                         input logic mode, input int rounds);
        logic [7:0] s, k;
        bit         dec;
        int         i;
        s   = data;
        dec = DEC_EN && mode;
        for (int j = 0; j < rounds; j++) begin
            i = dec ? (rounds - 1 - j) : j;
            k = m_rotl(key, i % 8) ^ 8'(i);
            if (dec) s = m_rotl(s - k, 8 - ROT) ^ k;
            else     s = m_rotl(s ^ k, ROT) + k;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_key(input int d, input logic [7:0] k);
        key_load_s[d] = 1'b1;
        key_in_s[d]   = k;
        @(posedge clk); #1;
        key_load_s[d] = 1'b0;
    endtask

    task automatic accept_only(input int d, input logic [7:0] data, input logic mode);
        int n;
        n = 0;
        while (!in_ready_s[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", in_ready_s[d], 1'b1);
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = data;
        in_mode_s[d]  = mode;
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input int elapsed);
        int n;
        n = elapsed;
        while (!out_valid_s[d] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, rounds_of(d));
    endtask

    task automatic handshake(input int d, output logic [7:0] res);
        res            = out_data_s[d];
        out_ready_s[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[d] = 1'b0;
    endtask

    task automatic run_block(input int d, input logic [7:0] data, input logic mode,
                             output logic [7:0] res);
        accept_only(d, data, mode);
        wait_out(d, 0);
        handshake(d, res);
    endtask

    typedef struct {
        logic [7:0] key;
        logic [7:0] data;
        logic       mode;
        logic [7:0] exp;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] r, r2, cur_key, held, d8;
        logic       md;
        int         rdy_cyc[$];

        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; key_load_s[d] = 1'b0; key_in_s[d] = 8'h00;
            in_valid_s[d] = 1'b0; in_data_s[d] = 8'h00; in_mode_s[d] = 1'b0;
            out_ready_s[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_in_ready%0d", d), in_ready_s[d], 1'b0);
            check($sformatf("rst_key_valid%0d", d), key_valid_s[d], 1'b0);
            check($sformatf("rst_out_valid%0d", d), out_valid_s[d], 1'b0);
            check($sformatf("rst_out_data%0d", d), out_data_s[d], 8'h00);
            check($sformatf("rst_busy%0d", d), busy_s[d], 1'b0);
        end
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(posedge clk); #1;

        // ROUNDS=1 known-answer vectors
        tbl[0] = '{key: 8'h00, data: 8'h01, mode: 1'b0, exp: 8'h08};
        tbl[1] = '{key: 8'h01, data: 8'h00, mode: 1'b0, exp: 8'h09};
        tbl[2] = '{key: 8'h00, data: 8'h80, mode: 1'b0, exp: 8'h04};
        tbl[3] = '{key: 8'hFF, data: 8'h00, mode: 1'b0, exp: 8'hFE};
        tbl[4] = '{key: 8'h10, data: 8'h0F, mode: 1'b0, exp: 8'h08};
        tbl[5] = '{key: 8'h00, data: 8'h01, mode: 1'b1, exp: (DEC_EN ? 8'h20 : 8'h08)};
        for (int i = 0; i < 6; i++) begin
            load_key(0, tbl[i].key);
            run_block(0, tbl[i].data, tbl[i].mode, r);
            check($sformatf("tbl%0d", i), r, tbl[i].exp);
        end
        load_key(0, 8'h00);
        run_block(0, 8'h08, 1'b1, r);
        check("tbl_dec_08", r, DEC_EN ? 8'h01 : 8'h40);

        // no key loaded: offers are ignored
        in_valid_s[1] = 1'b1;
        in_data_s[1]  = 8'h55;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("nokey_in_ready", in_ready_s[1], 1'b0);
            check("nokey_busy", busy_s[1], 1'b0);
        end
        in_valid_s[1] = 1'b0;

        cur_key = 8'h3C;
        load_key(1, cur_key);
        check("key_valid_set", key_valid_s[1], 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur_key = 8'($urandom);
                load_key(1, cur_key);
            end
            d8 = 8'($urandom);
            md = 1'($urandom);
            run_block(1, d8, md, r);
            check($sformatf("rand%0d", i), r, model(cur_key, d8, md, 4));
        end

        // exhaustive encrypt/decrypt round trip
        cur_key = 8'hA7;
        load_key(1, cur_key);
        for (int v = 0; v < 256; v++) begin
            run_block(1, 8'(v), 1'b0, r);
            if (v == 8'hA5) check("enc_a5", r, model(cur_key, 8'hA5, 1'b0, 4));
            run_block(1, r, 1'b1, r2);
            check($sformatf("rt%0d", v), r2, DEC_EN ? 8'(v) : model(cur_key, r, 1'b1, 4));
        end

        // result held in DONE with out_ready low; new key accepted meanwhile
        cur_key = 8'h5A;
        load_key(1, cur_key);
        accept_only(1, 8'hC3, 1'b0);
        wait_out(1, 0);
        held = model(cur_key, 8'hC3, 1'b0, 4);
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", out_valid_s[1], 1'b1);
            check("hold_out_data", out_data_s[1], held);
            check("hold_in_ready", in_ready_s[1], 1'b0);
            key_load_s[1] = (c == 1);
            key_in_s[1]   = 8'h99;
            @(posedge clk); #1;
            key_load_s[1] = 1'b0;
        end
        handshake(1, r);
        check("hold_result", r, held);
        cur_key = 8'h99;
        run_block(1, 8'hC3, 1'b0, r);
        check("key_in_done", r, model(cur_key, 8'hC3, 1'b0, 4));

        // key_load during RUN is ignored
        accept_only(1, 8'h11, 1'b0);
        load_key(1, 8'h42);
        wait_out(1, 1);
        handshake(1, r);
        check("key_in_run_blk", r, model(cur_key, 8'h11, 1'b0, 4));
        run_block(1, 8'h22, 1'b0, r);
        check("key_in_run_next", r, model(cur_key, 8'h22, 1'b0, 4));

        // key_load coinciding with accept: old key for this block
        in_valid_s[1] = 1'b1; in_data_s[1] = 8'h77; in_mode_s[1] = 1'b0;
        key_load_s[1] = 1'b1; key_in_s[1] = 8'hE1;
        check("simul_ready", in_ready_s[1], 1'b1);
        @(posedge clk); #1;
        in_valid_s[1] = 1'b0; key_load_s[1] = 1'b0;
        wait_out(1, 0);
        handshake(1, r);
        check("simul_old_key", r, model(cur_key, 8'h77, 1'b0, 4));
        cur_key = 8'hE1;
        run_block(1, 8'h77, 1'b0, r);
        check("simul_new_key", r, model(cur_key, 8'h77, 1'b0, 4));

        // back-to-back throughput
        in_valid_s[1] = 1'b1; in_data_s[1] = 8'h3E; in_mode_s[1] = 1'b0;
        out_ready_s[1] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (in_ready_s[1]) rdy_cyc.push_back(c);
            @(posedge clk); #1;
        end
        in_valid_s[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        out_ready_s[1] = 1'b0;
        check("tput_count", rdy_cyc.size(), 4);
        for (int k = 1; k < rdy_cyc.size(); k++)
            check($sformatf("tput_gap%0d", k), rdy_cyc[k] - rdy_cyc[k-1], 6);

        // reset in the second RUN cycle discards the block
        accept_only(1, 8'hAB, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_busy_pre", busy_s[1], 1'b1);
        rst_s[1] = 1'b1;
        @(posedge clk); #1;
        rst_s[1] = 1'b0;
        check("rst_mid_busy", busy_s[1], 1'b0);
        check("rst_mid_key_valid", key_valid_s[1], 1'b0);
        check("rst_mid_out_valid", out_valid_s[1], 1'b0);
        check("rst_mid_in_ready", in_ready_s[1], 1'b0);
        check("rst_mid_out_data", out_data_s[1], 8'h00);
        in_valid_s[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("rst_after_out_valid", out_valid_s[1], 1'b0);
            check("rst_after_busy", busy_s[1], 1'b0);
        end
        in_valid_s[1] = 1'b0;
        cur_key = 8'h0D;
        load_key(1, cur_key);
        run_block(1, 8'hAB, 1'b0, r);
        check("rst_recover", r, model(cur_key, 8'hAB, 1'b0, 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cifrador_param_core.md
CIFRADOR_PARAM_CORE -- requirements
Module: cifrador_param_core

Interface
REQ-001 Parameter WIDTH, default 8: data and key word width in bits; legal range 4..64.
REQ-002 Parameter ROUNDS, default 4: number of cipher rounds; legal range 1..255.
REQ-003 Parameter ROT, default 3: rotate amount per round; legal range 1..WIDTH-1.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous reset, active-high.
REQ-006 Port key_load, input, 1: load key_in into the key register.
REQ-007 Port key_in, input, WIDTH: key value.
REQ-008 Port in_valid, input, 1: input block offered.
REQ-009 Port in_ready, output, 1: core can accept a block.
REQ-010 Port in_data, input, WIDTH: plaintext or ciphertext block.
REQ-011 Port in_mode, input, 1: 0 = encrypt, 1 = decrypt; sampled with in_data.
REQ-012 Port out_valid, output, 1: result available.
REQ-013 Port out_ready, input, 1: consumer accepts result.
REQ-014 Port out_data, output, WIDTH: result block.
REQ-015 Port busy, output, 1: high in RUN state.
REQ-016 Port key_valid, output, 1: a key has been loaded since reset.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IDLE after reset.
REQ-018 in_ready = (state == IDLE) && key_valid; purely registered-state derived, with no combinational path from any input.
REQ-019 Accept on in_valid && in_ready: latch in_data and in_mode, clear the round counter, go to RUN.
REQ-020 Round key k_i = rotl(key, i mod WIDTH) XOR i (i zero-extended or truncated to WIDTH).
REQ-021 Encrypt: rounds i = 0..ROUNDS-1, s <= rotl(s XOR k_i, ROT) + k_i, mod 2^WIDTH.
REQ-022 Decrypt: rounds i = ROUNDS-1 down to 0, s <= rotr(s - k_i, ROT) XOR k_i, mod 2^WIDTH; exact inverse of encrypt.
REQ-023 One round per clk cycle in RUN; after the last round go to DONE.
REQ-024 Latency: accept edge at cycle t gives out_valid = 1 in cycle t+ROUNDS.
REQ-025 DONE: out_valid = 1; out_data holds the result stable until out_valid && out_ready, then go to IDLE.
REQ-026 Back-to-back throughput: at most one block per ROUNDS+2 cycles.
REQ-027 key_load is honoured in IDLE and DONE and ignored in RUN; it sets key_valid = 1.
REQ-028 Simultaneous key_load and accept in IDLE: the accepted block uses the old key, and the new key applies from the next block.
REQ-029 If key_valid = 0, in_ready = 0 and in_valid is ignored.

Reset
REQ-030 rst = 1 at a clk edge: state = IDLE, round counter = 0, key = 0, key_valid = 0, out_valid = 0, out_data = 0, busy = 0, in_ready = 0.
REQ-031 Reset mid-RUN or mid-DONE discards the block with no output handshake; rst has priority over all other inputs.

Configuration
REQ-032 Macro CIFRADOR_DECRYPT_EN defined: the decrypt datapath is present and in_mode is honoured.
REQ-033 Macro CIFRADOR_DECRYPT_EN undefined: no decrypt logic is built, in_mode is ignored, and every block is encrypted.

Structure
REQ-034 Shared package cifrador_pkg: FSM state enum, rotl/rotr functions, and the round-key function.
REQ-035 Sub-module cifrador_round: combinational single round (inputs s, k_i, mode; output s_next), instantiated once and reused iteratively.
REQ-036 Illegal WIDTH, ROUNDS or ROT values SHALL fail at elaboration.

Verification
REQ-037 Defaults with ROUNDS=1, key 0x00, encrypt 0x01 -> out_data 0x08, out_valid 1 cycle after accept.
REQ-038 ROUNDS=1, key 0x01, encrypt 0x00 -> out_data 0x09.
REQ-039 Defaults: encrypt 0xA5, then decrypt the result with the same key -> 0xA5. Repeat for all 256 values; all SHALL round-trip.
REQ-040 out_ready held low 5 cycles in DONE -> out_valid stays 1, out_data constant, in_ready 0, and a key_load of a new key does not alter the held result.
REQ-041 rst pulsed in the 2nd RUN cycle -> next cycle IDLE, key_valid 0, out_valid 0, no output emitted; in_valid ignored until a new key_load.
REQ-042 Build without CIFRADOR_DECRYPT_EN, in_mode = 1, data 0x01, key 0x00, ROUNDS=1 -> out_data 0x08 (encrypt).
